cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Generates the 6502 PHI2 clock from the 12 MHz board clock and controls it. It supports free-running, halt and single-step modes, and stretches the PHI2-high phase with wait states for slow peripherals. It sits in the CPLD between the oscillator input and the CPU/bus decode logic. It supersedes the fixed divider for the CPU clock, and its edge strobes give downstream logic a synchronous view of bus-cycle timing.

## Interface
Parameters:
- DIV, 12: clk_in cycles per unstretched PHI2 period. Must be even, 4..256. Nominal low/high half = DIV/2.
- RUN_ON_RESET, 1: selects the state after reset. 1 = RUN, 0 = HALT.

Ports:
- clk_in  input  1  board clock (12 MHz); the only clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level. 1 = free-run PHI2; 0 = halt at the next cycle boundary.
- step  input  1  single-cycle pulse. While halted, requests exactly one PHI2 period.
- stretch_req  input  1  slow-device select, sampled in the phi2_rise cycle.
- wait_cycles  input  4  extra high-phase clk_in cycles (0..15), sampled with stretch_req.
- phi2  output  1  CPU clock, registered, glitch-free.
- phi2_rise  output  1  one-cycle strobe, high in the first clk_in cycle with phi2=1.
- phi2_fall  output  1  one-cycle strobe, high in the first clk_in cycle with phi2=0 after a high phase.
- halted  output  1  1 while in HALT (phi2 held low).

## Operation
- Phase counter cnt has width $clog2(DIV) and counts 0..DIV-1. A separate 4-bit wait counter wcnt is used for stretching.
- States:
  - RUN: cycles continuously.
  - HALT: cnt=0, phi2=0, halted=1.
  - STEP: runs one period, then returns to HALT.
- Period structure:
  - Low phase: cnt 0..DIV/2-1, phi2=0.
  - High phase: cnt DIV/2..DIV-1, phi2=1, extended by wcnt.
- Stretch:
  - In the phi2_rise cycle, if stretch_req=1, load wcnt=wait_cycles; otherwise load 0.
  - When cnt=DIV-1 and wcnt≠0, cnt holds and wcnt decrements.
  - High phase is exactly DIV/2+wcnt_loaded cycles.
  - stretch_req/wait_cycles are ignored in all other cycles.
- Cycle boundary: the edge leaving the last high cycle. At that edge phi2→0, phi2_fall→1 and cnt→0. Next state:
  - RUN or STEP → RUN if run=1, else HALT.
- HALT transitions:
  - run=1 → RUN.
  - Else step=1 → STEP.
  - Both high → RUN; step is ignored.
  - The low phase starts at cnt=0 on the next cycle, so the first low phase is a full DIV/2 cycles.
- run deasserted mid-cycle: the current period completes unchanged, including any stretch. run is only sampled at the boundary; a deassert-reassert pulse between boundaries has no effect.
- step outside HALT is ignored and not queued.
- phi2 never produces a runt pulse. Each low phase is ≥DIV/2 cycles and each high phase ≥DIV/2 cycles.
- Reset:
  - Any cycle, including mid-high or mid-stretch.
  - Next edge: phi2=0, phi2_rise=0, phi2_fall=0, cnt=0, wcnt=0.
  - halted = !RUN_ON_RESET; state = RUN_ON_RESET ? RUN : HALT.
  - No phi2_fall strobe is emitted for a reset-truncated high phase.

## Timing
- All outputs are registered; no combinational input→output paths.
- phi2_rise/phi2_fall update on the same edge as phi2 and last exactly one clk_in cycle.
- RUN from reset (RUN_ON_RESET=1, DIV=12): the first phi2 rise occurs 6 cycles after reset is released. Period is 12 cycles (1 MHz at 12 MHz).
- HALT→RUN latency: run sampled high at edge E → state RUN at E, first rise at E+6 (DIV=12). halted drops at E.
- RUN→HALT: halted rises on the boundary edge, coincident with phi2_fall.
- Stretch: wait_cycles=N gives a period of DIV+N cycles. The next low phase is unaffected.

## Test plan
- Reset, RUN_ON_RESET=1, DIV=12, run=1, 5 periods → phi2 6 low/6 high, one rise and one fall strobe per period, halted=0.
- stretch_req=1, wait_cycles=3 at rise → high 9 cycles, period 15. stretch_req asserted outside the rise cycle → no effect. wait_cycles=0 → 12-cycle period.
- Drop run 2 cycles after a rise → phase completes (high 6 cycles), halted=1 on fall edge, phi2 stays 0 for 50 cycles.
- Halted, 1-cycle step pulse → exactly one 12-cycle period (one rise, one fall), then halted=1. Step during that period → ignored. Simultaneous step+run → free-run.
- Assert reset 3 cycles into a stretched high phase → next cycle phi2=0 with no fall strobe, then restart per RUN_ON_RESET. Repeat with RUN_ON_RESET=0 → halted=1 until run is asserted.
- DIV=4 build → 2 low/2 high. wait_cycles=15 → high 17 cycles, period 19.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// PHI2 clock generator for the 6502: divides clk_in by DIV and supports
// free-run, halt and single-step, with wait-state stretching of the high phase.
module cpu_clk_ctrl #(
  parameter int unsigned DIV          = 12,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       stretch_req,
  input  logic [3:0] wait_cycles,
  output logic       phi2,
  output logic       phi2_rise,
  output logic       phi2_fall,
  output logic       halted
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] PRE_RISE = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_STEP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          phi2_q, phi2_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          halted_q, halted_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= RUN_ON_RESET ? S_RUN : S_HALT;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      phi2_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      halted_q <= !RUN_ON_RESET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      phi2_q   <= phi2_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    phi2_d   = phi2_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    halted_d = halted_q;

    case (state_q)
      S_RUN, S_STEP: begin
        // rise_q marks the first high cycle, the only one that samples stretch
        if (rise_q) begin
          wcnt_d = stretch_req ? wait_cycles : '0;
        end
        if (cnt_q == LAST) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            cnt_d  = '0;
            phi2_d = 1'b0;
            fall_d = 1'b1;
            if (run) begin
              state_d  = S_RUN;
              halted_d = 1'b0;
            end else begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PRE_RISE) begin
            phi2_d = 1'b1;
            rise_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d    = '0;
        wcnt_d   = '0;
        phi2_d   = 1'b0;
        halted_d = 1'b1;
        if (run) begin
          state_d  = S_RUN;
          halted_d = 1'b0;
        end else if (step) begin
          state_d  = S_STEP;
          halted_d = 1'b0;
        end
      end
    endcase
  end

  assign phi2      = phi2_q;
  assign phi2_rise = rise_q;
  assign phi2_fall = fall_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: two DIV=12 builds (run/halt after reset) and a DIV=4 build.
module tb_cpu_clk_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic       stretch = 1'b0;
  logic [3:0] wc = '0;
  logic       stretch_c = 1'b0;
  logic [3:0] wc_c = '0;

  logic phi2_a, rise_a, fall_a, halted_a;
  logic phi2_b, rise_b, fall_b, halted_b;
  logic phi2_c, rise_c, fall_c, halted_c;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DIV(12), .RUN_ON_RESET(1'b1)) u_a (
    .clk_in(clk), .reset(reset), .run(run), .step(step),
    .stretch_req(stretch), .wait_cycles(wc),
    .phi2(phi2_a), .phi2_rise(rise_a), .phi2_fall(fall_a), .halted(halted_a));

  cpu_clk_ctrl #(.DIV(12), .RUN_ON_RESET(1'b0)) u_b (
    .clk_in(clk), .reset(reset), .run(run), .step(step),
    .stretch_req(stretch), .wait_cycles(wc),
    .phi2(phi2_b), .phi2_rise(rise_b), .phi2_fall(fall_b), .halted(halted_b));

  cpu_clk_ctrl #(.DIV(4), .RUN_ON_RESET(1'b1)) u_c (
    .clk_in(clk), .reset(reset), .run(run), .step(step),
    .stretch_req(stretch_c), .wait_cycles(wc_c),
    .phi2(phi2_c), .phi2_rise(rise_c), .phi2_fall(fall_c), .halted(halted_c));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait for a rise/fall strobe of DUT d (0=a, 1=b, 2=c); c_out is the cycle it was seen.
  task automatic wait_ev(input string name, input int d, input bit want_fall,
                         input int lim, output int c_out);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      case (d)
        0:       got = want_fall ? fall_a : rise_a;
        1:       got = want_fall ? fall_b : rise_b;
        default: got = want_fall ? fall_c : rise_c;
      endcase
      if (got) break;
    end
    c_out = cyc;
    chk({"wait_", name}, int'(got), 1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard for DUT a: expected high-phase lengths, pushed when a period is driven.
  int exp_hi_q[$];
  bit mon_a = 1'b0;
  int hi_cnt = 0;
  int lo_cnt = 0;
  bit prev_phi2 = 1'b0;
  bit prev_rst = 1'b1;

  always @(negedge clk) begin
    if (mon_a) begin
      if (phi2_a != prev_phi2 || rise_a || fall_a) begin
        chk("rise_strobe", int'(rise_a), int'(phi2_a && !prev_phi2));
        chk("fall_strobe", int'(fall_a), int'(!phi2_a && prev_phi2 && !prev_rst));
      end
      if (rise_a) chk("low_phase_ge_6", int'(lo_cnt >= 6), 1);
      if (fall_a) begin
        chk("fall_expected", int'(exp_hi_q.size() > 0), 1);
        if (exp_hi_q.size() > 0) chk("high_len", hi_cnt, exp_hi_q.pop_front());
      end
    end
    if (phi2_a) begin
      hi_cnt++;
      lo_cnt = 0;
    end else begin
      lo_cnt++;
      hi_cnt = 0;
    end
    prev_phi2 = phi2_a;
    prev_rst  = reset;
  end

  typedef struct {
    bit s;
    int w;
    bit late;
    bit rp;
    int hi;
    int per;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c, c2, tp, t0, cnt_hi, cnt_bad;

    for (int i = 0; i < 5; i++) vecs[i] = '{0, 0, 0, 0, 6, 12};
    vecs[5]  = '{1, 3, 0, 0, 9, 15};
    vecs[6]  = '{0, 5, 1, 0, 6, 12};
    vecs[7]  = '{1, 0, 0, 0, 6, 12};
    vecs[8]  = '{0, 7, 0, 0, 6, 12};
    vecs[9]  = '{1, 15, 0, 0, 21, 27};
    vecs[10] = '{0, 0, 0, 1, 6, 12};
    vecs[11] = '{0, 0, 0, 0, 6, 12};

    // Reset state
    tick(3);
    chk("rst_phi2_a", phi2_a, 0);
    chk("rst_rise_a", rise_a, 0);
    chk("rst_fall_a", fall_a, 0);
    chk("rst_halted_a", halted_a, 0);
    chk("rst_halted_b", halted_b, 1);
    chk("rst_halted_c", halted_c, 0);
    reset = 1'b0;
    t0 = cyc;
    mon_a = 1'b1;

    wait_ev("first_rise", 0, 0, 20, c);
    chk("first_rise_latency", c - t0, 6);
    chk("run_halted_a", halted_a, 0);

    tp = c;
    for (int i = 0; i < 12; i++) begin
      exp_hi_q.push_back(vecs[i].hi);
      if (!vecs[i].late) begin
        stretch = vecs[i].s;
        wc      = vecs[i].w[3:0];
      end
      tick(1);
      stretch = 1'b0;
      wc      = '0;
      if (vecs[i].late) begin
        stretch = 1'b1;
        wc      = vecs[i].w[3:0];
        tick(1);
        stretch = 1'b0;
        wc      = '0;
      end
      if (vecs[i].rp) begin
        run = 1'b0;
        tick(2);
        run = 1'b1;
      end
      wait_ev("vec_rise", 0, 0, 64, c);
      chk($sformatf("period[%0d]", i), c - tp, vecs[i].per);
      tp = c;
    end

    // Drop run two cycles after a rise: the period completes, then halt
    exp_hi_q.push_back(6);
    tick(2);
    run = 1'b0;
    wait_ev("drop_fall", 0, 1, 32, c2);
    chk("drop_high_len", c2 - c, 6);
    chk("drop_halted_at_fall", halted_a, 1);
    cnt_hi = 0;
    cnt_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (phi2_a) cnt_hi++;
      if (!halted_a) cnt_bad++;
    end
    chk("halt_phi2_high_cycles", cnt_hi, 0);
    chk("halt_not_halted_cycles", cnt_bad, 0);

    // Single step, with a second step inside the stepped period ignored
    step = 1'b1;
    tick(1);
    step = 1'b0;
    t0 = cyc;
    chk("step_halted_drops", halted_a, 0);
    exp_hi_q.push_back(6);
    wait_ev("step_rise", 0, 0, 20, c);
    chk("step_rise_latency", c - t0, 6);
    tick(2);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    wait_ev("step_fall", 0, 1, 20, c2);
    chk("step_period", c2 - t0, 12);
    chk("step_halted_after", halted_a, 1);
    cnt_hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (rise_a) cnt_hi++;
    end
    chk("step_no_extra_rise", cnt_hi, 0);

    // step and run together: free-run
    step = 1'b1;
    run  = 1'b1;
    tick(1);
    step = 1'b0;
    t0 = cyc;
    chk("steprun_halted", halted_a, 0);
    for (int k = 0; k < 3; k++) begin
      wait_ev("steprun_rise", 0, 0, 30, c);
      chk($sformatf("steprun_interval[%0d]", k), c - t0, (k == 0) ? 6 : 12);
      t0 = c;
      exp_hi_q.push_back(6);
    end

    // Reset three cycles into a stretched high phase
    wait_ev("pre_reset_rise", 0, 0, 30, c);
    stretch = 1'b1;
    wc      = 4'd8;
    tick(1);
    stretch = 1'b0;
    wc      = '0;
    tick(1);
    reset = 1'b1;
    run   = 1'b0;
    tick(1);
    chk("trunc_phi2_a", phi2_a, 0);
    chk("trunc_fall_a", fall_a, 0);
    chk("trunc_halted_a", halted_a, 0);
    chk("trunc_halted_b", halted_b, 1);
    reset = 1'b0;
    t0 = cyc;
    exp_hi_q.push_back(6);
    wait_ev("post_reset_rise", 0, 0, 20, c);
    chk("post_reset_latency", c - t0, 6);
    wait_ev("post_reset_fall", 0, 1, 40, c2);
    chk("post_reset_high_len", c2 - c, 6);
    chk("post_reset_halted_a", halted_a, 1);

    // RUN_ON_RESET=0 build stays halted until run
    cnt_hi = 0;
    cnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (phi2_b) cnt_hi++;
      if (!halted_b) cnt_bad++;
    end
    chk("b_phi2_high_cycles", cnt_hi, 0);
    chk("b_not_halted_cycles", cnt_bad, 0);
    mon_a = 1'b0;
    run = 1'b1;
    tick(1);
    t0 = cyc;
    chk("b_halted_drops", halted_b, 0);
    wait_ev("b_rise", 1, 0, 20, c);
    chk("b_rise_latency", c - t0, 6);

    // DIV=4 build: 2/2 nominal, 2+15 high with maximum stretch
    wait_ev("c_rise0", 2, 0, 20, c);
    wait_ev("c_fall0", 2, 1, 20, c2);
    chk("c_high_len", c2 - c, 2);
    wait_ev("c_rise1", 2, 0, 20, t0);
    chk("c_period", t0 - c, 4);
    stretch_c = 1'b1;
    wc_c      = 4'd15;
    tick(1);
    stretch_c = 1'b0;
    wc_c      = '0;
    wait_ev("c_fall1", 2, 1, 40, c2);
    chk("c_stretch_high_len", c2 - t0, 17);
    wait_ev("c_rise2", 2, 0, 40, c);
    chk("c_stretch_period", c - t0, 19);

    chk("scoreboard_drained", exp_hi_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
